// File: rtl/twobitcount_checker_pkg.sv
// Shared types and defaults for the two-bit up-count sequence checker.
// Latency: n/a (types only).
// Backpressure: n/a.
package twobitcount_checker_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2,
        ERR    = 2'd3
    } state_t;

    typedef logic [1:0] cnt2_t;

    localparam int LOCK_N_DEF = 2;
    localparam int WRAP_W_DEF = 8;

endpackage

// File: rtl/twobitcount_checker_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
// Latency: count updates on the edge after inc/clr.
// Backpressure: none; inc is ignored once the counter is all-ones.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         Clock,
    input  logic         Reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !(&count)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/twobitcount_checker.sv
// Checks that {Q_A,Q_B} follows a mod-4 up-count, locking after LOCK_N good steps.
// Latency: locked/err_pulse/expected are decodes of state registered on the sampling edge.
// Backpressure: none; Enable qualifies samples, Enable=0 freezes tracking.
module twobitcount_checker
    import twobitcount_checker_pkg::*;
#(
    parameter int LOCK_N = LOCK_N_DEF,
    parameter int WRAP_W = WRAP_W_DEF
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Enable,
    input  logic              Clear,
    input  logic              Q_A,
    input  logic              Q_B,
    output logic              locked,
    output logic              err_pulse,
    output logic              err_sticky,
    output logic [WRAP_W-1:0] wrap_count,
    output cnt2_t             expected
);

    localparam logic [3:0] LOCK_N_C = 4'(LOCK_N);

    state_t     state;
    cnt2_t      prev;
    logic [3:0] good_cnt;

    cnt2_t      cur;
    cnt2_t      nxt;
    logic [3:0] good_inc;
    logic       match;
    logic       wrap_inc;
    logic       err_set;

    assign cur      = {Q_A, Q_B};
    assign nxt      = prev + 2'd1;
    assign match    = (cur == nxt);
    assign good_inc = good_cnt + 4'd1;

    // A match from prev==3 can only be cur==0, so this is exactly a 3->0 wrap.
    assign wrap_inc = (state == LOCKED) && Enable && match && (prev == 2'd3);
    assign err_set  = (state == LOCKED) && Enable && !match;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state    <= IDLE;
            prev     <= 2'd0;
            good_cnt <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (Enable) begin
                        prev     <= cur;
                        good_cnt <= 4'd0;
                        state    <= SYNC;
                    end
                end
                SYNC: begin
                    if (Enable) begin
                        prev <= cur;
                        if (match) begin
                            good_cnt <= good_inc;
                            if (good_inc == LOCK_N_C) begin
                                state <= LOCKED;
                            end
                        end else begin
                            good_cnt <= 4'd0;
                        end
                    end
                end
                LOCKED: begin
                    if (Enable) begin
                        prev <= cur;
                        if (!match) begin
                            state <= ERR;
                        end
                    end
                end
                ERR: begin
                    // Leaves after one cycle whether or not this edge samples.
                    if (Enable) begin
                        prev <= cur;
                    end
                    good_cnt <= 4'd0;
                    state    <= SYNC;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            err_sticky <= 1'b0;
        end else if (Clear) begin
            err_sticky <= 1'b0;
        end else if (err_set) begin
            err_sticky <= 1'b1;
        end
    end

    sat_counter #(
        .W (WRAP_W)
    ) u_wrap_cnt (
        .Clock (Clock),
        .Reset (Reset),
        .inc   (wrap_inc),
        .clr   (Clear),
        .count (wrap_count)
    );

    assign locked    = (state == LOCKED);
    assign err_pulse = (state == ERR);
    assign expected  = nxt;

endmodule

// File: doc/twobitcount_checker.md
TWOBITCOUNT_CHECKER -- requirements
Module: twobitcount_checker

Interface
REQ-001 The block SHALL have parameter LOCK_N, default 2, meaning the number of consecutive correct increments needed to declare lock (legal range 1..15).
REQ-002 The block SHALL have parameter WRAP_W, default 8, meaning the width of the wrap counter.
REQ-003 Port Clock  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port Reset  input  1  SHALL be the asynchronous, active-low reset (0 = reset asserted).
REQ-005 Port Enable  input  1  SHALL be the sample qualifier; Q_A/Q_B are sampled only on edges where Enable=1.
REQ-006 Port Clear  input  1  SHALL be a synchronous clear of err_sticky and wrap_count.
REQ-007 Port Q_A  input  1  SHALL be the observed counter MSB.
REQ-008 Port Q_B  input  1  SHALL be the observed counter LSB.
REQ-009 Port locked  output  1  SHALL indicate that the checker is tracking a valid up-count.
REQ-010 Port err_pulse  output  1  SHALL be a one-cycle flag marking a sequence violation while locked.
REQ-011 Port err_sticky  output  1  SHALL be a latched violation flag.
REQ-012 Port wrap_count  output  WRAP_W  SHALL count observed 3->0 wraps while locked.
REQ-013 Port expected  output  2  SHALL be the next value expected, {Q_A,Q_B} = prev+1 mod 4.

Function
REQ-014 The block SHALL form cur = {Q_A,Q_B} and keep prev (2 bits), good_cnt (4 bits) and state in {IDLE, SYNC, LOCKED, ERR}.
REQ-015 IDLE: on Enable=1, the block SHALL set prev=cur, set good_cnt=0 and go to SYNC.
REQ-016 SYNC, Enable=1, cur==prev+1 mod 4: the block SHALL increment good_cnt; when the new count equals LOCK_N it SHALL go to LOCKED.
REQ-017 SYNC, Enable=1, mismatch: the block SHALL set good_cnt=0 and stay in SYNC.
REQ-018 In SYNC and LOCKED, every sampled edge SHALL set prev=cur.
REQ-019 LOCKED, Enable=1, match: the block SHALL stay in LOCKED; if prev==3 and cur==0, wrap_count SHALL increment, saturating at all-ones.
REQ-020 LOCKED, Enable=1, mismatch (including a repeated value): the block SHALL set err_sticky, set prev=cur and go to ERR.
REQ-021 ERR: the block SHALL go to SYNC with good_cnt=0 on the next edge regardless of Enable; a sample taken in ERR with Enable=1 SHALL update prev only.
REQ-022 Enable=0: state, prev, good_cnt and wrap_count SHALL hold (ERR still exits per REQ-021).
REQ-023 Outputs SHALL be registered-state decodes: locked=(state==LOCKED), err_pulse=(state==ERR), expected=prev+1 mod 4.
REQ-024 Latency: locked SHALL rise in the cycle after the edge sampling the LOCK_N-th consecutive correct increment; err_pulse SHALL rise in the cycle after the mismatching edge, for exactly one cycle.
REQ-025 Clear=1 SHALL zero err_sticky and wrap_count on that edge and take priority over a same-edge set or increment; state SHALL be unaffected.

Reset
REQ-026 Reset=0 SHALL immediately force state=IDLE, prev=0, good_cnt=0, locked=0, err_pulse=0, err_sticky=0, wrap_count=0, expected=1, including mid-lock or mid-error.
REQ-027 After Reset is released, the first sampled edge SHALL follow REQ-015.

Structure
REQ-028 A shared package SHALL hold the state enumeration, the 2-bit count type and the LOCK_N/WRAP_W defaults.
REQ-029 The saturating wrap counter SHALL be a sub-module named sat_counter (parameter W; inputs inc and clr; clr has priority).

Verification
REQ-030 The bench SHALL drive Enable=1 and inputs 0,1,2,3,0,1 with LOCK_N=2 and check that locked rises after the sample of 2, and that wrap_count=1 after the 3->0 step.
REQ-031 The bench SHALL, while locked at prev=1, drive 3 and check err_pulse=1 for one cycle, err_sticky=1, locked=0, then relock after two good increments.
REQ-032 The bench SHALL hold input 2 for two samples while locked and check the error path; in SYNC, it SHALL drive 0,2,3,0 and check that lock occurs only after 3,0.
REQ-033 The bench SHALL toggle Enable=0 for 3 cycles mid-lock while changing Q_A/Q_B freely, then resume with prev+1, and check no error and an unchanged wrap_count.
REQ-034 The bench SHALL run 300 locked wraps with WRAP_W=8 and check that wrap_count saturates at 255, and that Clear asserted on the same edge as a wrap yields 0.
REQ-035 The bench SHALL assert Reset=0 asynchronously between clock edges while in LOCKED and check that all outputs take their REQ-026 values immediately.
